flow_stack_ctrl: RTL and testbench

- Controls the processor's control-flow resources: the return-address stack (call/ret) and the enable-mask stack (pushen/popen/allen).
- Sits beside decode/PC-select. Decode issues one flow op per cycle; the block updates both stacks and supplies the return target to the newpc mux and the current enable bit to writeback gating.
- Detects stack overflow and underflow and raises a sticky halt request.

---
 rtl/flow_stack_ctrl_pkg.sv | 28 ++
 rtl/flow_lifo.sv | 62 ++++++
 rtl/flow_stack_ctrl.sv | 133 +++++++++++++
 tb/tb_flow_stack_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/flow_stack_ctrl_pkg.sv
// Shared definitions for the flow-control stack block: op encodings,
// fault codes, default PC width and the controller state type.
package flow_stack_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        FLOW_NONE   = 3'd0,
        FLOW_CALL   = 3'd1,
        FLOW_RET    = 3'd2,
        FLOW_PUSHEN = 3'd3,
        FLOW_POPEN  = 3'd4,
        FLOW_ALLEN  = 3'd5
    } flow_op_e;

    localparam logic [2:0] FAULT_NONE     = 3'd0;
    localparam logic [2:0] FAULT_RAS_OVF  = 3'd1;
    localparam logic [2:0] FAULT_RAS_UNF  = 3'd2;
    localparam logic [2:0] FAULT_EN_OVF   = 3'd3;
    localparam logic [2:0] FAULT_EN_UNF   = 3'd4;
    localparam logic [2:0] FAULT_ILLEGAL  = 3'd5;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFault = 1'b1
    } flow_state_e;

endpackage

// File: rtl/flow_lifo.sv
// Depth-counted LIFO built as a shift register: entry 0 is the top.
// Slots at or beyond the current depth always hold zero, so pops fill
// from below with 0. With wrap_i set, a push at full drops the oldest.
module flow_lifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             wrap_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned DepthW = $clog2(Depth + 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

    logic [Width-1:0]  entry_q [Depth];
    logic [Width-1:0]  entry_d [Depth];
    logic [DepthW-1:0] depth_q, depth_d;

    assign full_o  = (depth_q == DepthMax);
    assign empty_o = (depth_q == '0);
    assign top_o   = empty_o ? '0 : entry_q[0];

    // Next-state: push shifts entries down, pop shifts them up.
    always_comb begin
        entry_d = entry_q;
        depth_d = depth_q;
        if (push_i && (!full_o || wrap_i)) begin
            entry_d[0] = data_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                entry_d[i] = entry_q[i-1];
            end
            if (!full_o) begin
                depth_d = depth_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            for (int unsigned i = 0; i + 1 < Depth; i++) begin
                entry_d[i] = entry_q[i+1];
            end
            entry_d[Depth-1] = '0;
            depth_d = depth_q - 1'b1;
        end
    end

    // Storage and depth counter, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entry_q <= '{default: '0};
            depth_q <= '0;
        end else begin
            entry_q <= entry_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/flow_stack_ctrl.sv
// Control-flow resource controller: return-address stack (CALL/RET) and
// 1-bit enable-mask stack (PUSHEN/POPEN/ALLEN), with a sticky fault.
// Optional build macro FLOW_STACK_WRAP_EN: overflowing pushes discard the
// oldest entry instead of faulting.
module flow_stack_ctrl
    import flow_stack_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned EN_DEPTH  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] link_pc,
    input  logic             cond,
    output logic [WIDTH-1:0] ret_addr,
    output logic             ras_empty,
    output logic             en_top,
    output logic [5:0]       en_depth,
    output logic             halt_req,
    output logic [2:0]       fault_code
);

`ifdef FLOW_STACK_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    localparam logic [5:0] EnFull = 6'(EN_DEPTH);

    flow_state_e         state_q, state_d;
    logic [2:0]          fault_q, fault_d;
    logic [EN_DEPTH-1:0] en_q, en_d;
    logic [5:0]          en_depth_q, en_depth_d;
    logic                ras_push, ras_pop, ras_full;

    flow_lifo #(
        .Width (WIDTH),
        .Depth (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .wrap_i  (WrapEn),
        .data_i  (link_pc),
        .top_o   (ret_addr),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign op_ready   = (state_q == StRun);
    assign halt_req   = (state_q == StFault);
    assign fault_code = fault_q;
    assign en_top     = en_q[0];
    assign en_depth   = en_depth_q;

    // Decode the accepted op; a faulting op leaves both stacks untouched.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        en_d       = en_q;
        en_depth_d = en_depth_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (op_valid && op_ready) begin
            case (op)
                FLOW_NONE: ;
                FLOW_CALL: begin
                    if (!ras_full || WrapEn) begin
                        ras_push = 1'b1;
                    end else begin
                        state_d = StFault;
                        fault_d = FAULT_RAS_OVF;
                    end
                end
                FLOW_RET: begin
                    if (!ras_empty) begin
                        ras_pop = 1'b1;
                    end else begin
                        state_d = StFault;
                        fault_d = FAULT_RAS_UNF;
                    end
                end
                FLOW_PUSHEN: begin
                    if (en_depth_q != EnFull || WrapEn) begin
                        en_d = {en_q[EN_DEPTH-2:0], cond & en_q[0]};
                        if (en_depth_q != EnFull) begin
                            en_depth_d = en_depth_q + 6'd1;
                        end
                    end else begin
                        state_d = StFault;
                        fault_d = FAULT_EN_OVF;
                    end
                end
                FLOW_POPEN: begin
                    if (en_depth_q != 6'd1) begin
                        en_d       = {1'b0, en_q[EN_DEPTH-1:1]};
                        en_depth_d = en_depth_q - 6'd1;
                    end else begin
                        state_d = StFault;
                        fault_d = FAULT_EN_UNF;
                    end
                end
                FLOW_ALLEN: en_d[0] = 1'b1;
                default: begin
                    state_d = StFault;
                    fault_d = FAULT_ILLEGAL;
                end
            endcase
        end
    end

    // State, fault and enable-stack registers; reset wins over any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            fault_q    <= FAULT_NONE;
            en_q       <= EN_DEPTH'(1);
            en_depth_q <= 6'd1;
        end else begin
            state_q    <= state_d;
            fault_q    <= fault_d;
            en_q       <= en_d;
            en_depth_q <= en_depth_d;
        end
    end

endmodule

// File: tb/tb_flow_stack_ctrl.sv
// Scoreboard bench for flow_stack_ctrl: the driver pushes hand-computed
// expected state per op; a monitor on the falling edge pops and compares.
module tb_flow_stack_ctrl;

    typedef struct packed {
        logic [15:0] ra;
        logic        emp;
        logic        et;
        logic [5:0]  ed;
        logic        halt;
        logic [2:0]  fc;
        logic        rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op = 3'd0;
    logic [15:0] link_pc = 16'h0;
    logic        cond = 1'b0;
    logic [15:0] ret_addr;
    logic        ras_empty;
    logic        en_top;
    logic [5:0]  en_depth;
    logic        halt_req;
    logic [2:0]  fault_code;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    flow_stack_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op         (op),
        .link_pc    (link_pc),
        .cond       (cond),
        .ret_addr   (ret_addr),
        .ras_empty  (ras_empty),
        .en_top     (en_top),
        .en_depth   (en_depth),
        .halt_req   (halt_req),
        .fault_code (fault_code)
    );

    function automatic obs_t mk(input logic [15:0] ra, input logic emp, input logic et,
                                input logic [5:0] ed, input logic halt, input logic [2:0] fc,
                                input logic rdy);
        obs_t o;
        o = '{ra: ra, emp: emp, et: et, ed: ed, halt: halt, fc: fc, rdy: rdy};
        return o;
    endfunction

    // Apply one op across one rising edge, then queue the expected state.
    task automatic step(input logic r, input logic v, input logic [2:0] o,
                        input logic [15:0] lpc, input logic c, input obs_t e, input string nm);
        reset    = r;
        op_valid = v;
        op       = o;
        link_pc  = lpc;
        cond     = c;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        op_valid = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the registered state against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = mk(ret_addr, ras_empty, en_top, en_depth, halt_req, fault_code, op_ready);
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got ra=%h emp=%b et=%b ed=%0d halt=%b fc=%0d rdy=%b want ra=%h emp=%b et=%b ed=%0d halt=%b fc=%0d rdy=%b",
                         nm, a.ra, a.emp, a.et, a.ed, a.halt, a.fc, a.rdy,
                         e.ra, e.emp, e.et, e.ed, e.halt, e.fc, e.rdy);
            end
        end
    end

    initial begin
        obs_t rst_s;
        rst_s = mk(16'h0, 1'b1, 1'b1, 6'd1, 1'b0, 3'd0, 1'b1);

        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "reset");
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "idle");

        // RAS push/pop ordering
        step(1'b0, 1'b1, 3'd1, 16'h0010, 1'b0, mk(16'h0010, 0, 1, 1, 0, 0, 1), "call1");
        step(1'b0, 1'b1, 3'd1, 16'h0020, 1'b0, mk(16'h0020, 0, 1, 1, 0, 0, 1), "call2");
        step(1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, mk(16'h0010, 0, 1, 1, 0, 0, 1), "ret1");
        step(1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, rst_s, "ret2_empty");

        // RAS overflow
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 3'd1, 16'(i), 1'b0, mk(16'(i), 0, 1, 1, 0, 0, 1), "call_fill");
        end
`ifdef FLOW_STACK_WRAP_EN
        step(1'b0, 1'b1, 3'd1, 16'h0005, 1'b0, mk(16'h0005, 0, 1, 1, 0, 0, 1), "call_wrap");
        step(1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, mk(16'h0004, 0, 1, 1, 0, 0, 1), "ret_after_wrap");
`else
        step(1'b0, 1'b1, 3'd1, 16'h0005, 1'b0, mk(16'h0004, 0, 1, 1, 1, 1, 0), "call_ovf");
        step(1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, mk(16'h0004, 0, 1, 1, 1, 1, 0), "ret_ignored");
`endif
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "reset_clear");

        // Enable stack
        step(1'b0, 1'b1, 3'd3, 16'h0, 1'b0, mk(16'h0, 1, 0, 2, 0, 0, 1), "pushen_c0");
        step(1'b0, 1'b1, 3'd3, 16'h0, 1'b1, mk(16'h0, 1, 0, 3, 0, 0, 1), "pushen_masked");
        step(1'b0, 1'b1, 3'd5, 16'h0, 1'b0, mk(16'h0, 1, 1, 3, 0, 0, 1), "allen");
        step(1'b0, 1'b1, 3'd4, 16'h0, 1'b0, mk(16'h0, 1, 0, 2, 0, 0, 1), "popen1");
        step(1'b0, 1'b1, 3'd4, 16'h0, 1'b0, mk(16'h0, 1, 1, 1, 0, 0, 1), "popen2");
        step(1'b0, 1'b1, 3'd4, 16'h0, 1'b0, mk(16'h0, 1, 1, 1, 1, 4, 0), "popen_unf");

        // Enable stack overflow
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "reset_en");
        for (int i = 2; i <= 32; i++) begin
            step(1'b0, 1'b1, 3'd3, 16'h0, 1'b1, mk(16'h0, 1, 1, 6'(i), 0, 0, 1), "pushen_fill");
        end
`ifdef FLOW_STACK_WRAP_EN
        step(1'b0, 1'b1, 3'd3, 16'h0, 1'b0, mk(16'h0, 1, 0, 32, 0, 0, 1), "pushen_wrap");
`else
        step(1'b0, 1'b1, 3'd3, 16'h0, 1'b0, mk(16'h0, 1, 1, 32, 1, 3, 0), "pushen_ovf");
`endif

        // Underflow and illegal op
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "reset_unf");
        step(1'b0, 1'b1, 3'd2, 16'h0, 1'b0, mk(16'h0, 1, 1, 1, 1, 2, 0), "ret_unf");
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "reset_ill");
        step(1'b0, 1'b0, 3'd6, 16'h0, 1'b0, rst_s, "op6_invalid");
        step(1'b0, 1'b1, 3'd6, 16'h0, 1'b0, mk(16'h0, 1, 1, 1, 1, 5, 0), "op6_illegal");

        // Reset during fault with a simultaneous CALL
        step(1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, rst_s, "reset_vs_call");
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, rst_s, "after_reset");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
